hazard_scoreboard_unit: RTL and testbench
=========================================

Name: hazard_scoreboard_unit

Overview:
- Next-generation hazard unit for the 5-stage MIPS pipeline. It takes over from the purely combinational forward/stall logic.
- Adds a parametrised register-address width, a multi-cycle multiply/divide (MDU) busy scoreboard, and structural and HI/LO read stalls.
- Adds taken-branch flush of the D stage.
- Sits beside the datapath. It drives forwarding muxes in D and E, and stall/flush enables for the F/D/E pipeline registers.

Parameters:
- REG_AW, 5: register-address width; register 0 is hard-wired zero and never forwarded or stalled on.
- MDU_LAT, 4: MDU occupancy in cycles, including the issue cycle; legal range 2..255.
- CNT_W, 8: MDU countdown width; must satisfy 2^CNT_W > MDU_LAT.
- PERF_W, 32: width of the optional stall counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rs_d, rt_d  in  REG_AW  source registers of the instruction in D
- rs_e, rt_e  in  REG_AW  source registers of the instruction in E
- regwrite_e, memtoreg_e  in  1  E-stage writes a register / is a load
- writereg_e  in  REG_AW  E-stage destination register
- regwrite_m, memtoreg_m  in  1  M-stage write / load
- writereg_m  in  REG_AW  M-stage destination register
- regwrite_w  in  1  W-stage write
- writereg_w  in  REG_AW  W-stage destination register
- branch_d  in  1  D holds a branch or jr that compares or uses registers in D
- branch_taken_d  in  1  branch resolved taken in D
- mdu_op_d  in  1  D holds mult/div
- mdu_rd_d  in  1  D holds mfhi/mflo
- mdu_start_e  in  1  mult/div issuing to the MDU this cycle (in E)
- forward_ae, forward_be  out  2  00 = register file, 01 = W result, 10 = M result
- forward_ad, forward_bd  out  1  1 = use the M result in the D comparator
- stall_f, stall_d  out  1  hold the PC and the F/D register
- flush_e  out  1  clear the D/E register (insert bubble)
- flush_d  out  1  clear the F/D register
- mdu_busy  out  1  MDU occupied

Behaviour:
- Forwarding is combinational. For A and B independently:
  - forward_xe = 10 when src != 0, src == writereg_m and regwrite_m.
  - Otherwise forward_xe = 01 when src != 0, src == writereg_w and regwrite_w.
  - Otherwise 00. M has priority over W.
  - forward_xd = 1 when src_d != 0, src_d == writereg_m and regwrite_m.
- Stall conditions (combinational, logically OR'd; every register match also requires src != 0):
  - Load-use: memtoreg_e and (rs_d == writereg_e or rt_d == writereg_e).
  - Branch-ALU: branch_d and regwrite_e and (rs_d or rt_d) == writereg_e.
  - Branch-load: branch_d and memtoreg_m and (rs_d or rt_d) == writereg_m.
  - HI/LO read: mdu_rd_d and mdu_busy.
  - Structural: mdu_op_d and mdu_busy.
- Any stall asserts stall_f = stall_d = flush_e = 1 in the same cycle.
- flush_d = branch_taken_d and not stall_d. A branch resolved while stalled is not acted on.
- MDU scoreboard, the only state:
  - cnt register, CNT_W bits.
  - On mdu_start_e, cnt <= MDU_LAT-1 at the next edge. Otherwise cnt decrements when nonzero.
  - mdu_busy = (cnt != 0) or mdu_start_e. This makes a back-to-back mult then mfhi stall from its first D cycle.
  - Worked case: start in cycle t gives mdu_busy high for cycles t .. t+MDU_LAT-1 and low at t+MDU_LAT.
  - mdu_start_e while cnt != 0 cannot occur when stalls are honoured. If it does occur, cnt reloads (restart wins).
- Reset (async, rst_n low): cnt = 0, and the perf counter = 0 when enabled.
  - All outputs are then 0, except those driven combinationally by live inputs.
  - Reset mid-MDU-operation abandons it; mdu_busy drops immediately.
- Stall and flush_d may not both be 1 in a cycle. flush_e may coincide with flush_d only when no stall is present (it does not, by construction).

Optional Feature:
- Macro HAZARD_STALL_PERF_EN.
- When defined:
  - Adds output stall_cnt, PERF_W bits.
  - Increments on every cycle with stall_d = 1.
  - Saturates at all-ones and never wraps.
  - Clears on reset.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - Forward-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10.
  - Default REG_AW and MDU_LAT.
- One sub-module, mdu_busy_tracker: the countdown plus mdu_busy generation, parametrised by MDU_LAT/CNT_W.
- Forward and stall logic stay in the top level.

Test Plan:
- Forward priority: writereg_m = writereg_w = 7, both regwrite, rs_e = 7 -> forward_ae = 10. Drop regwrite_m -> 01. Set rs_e = 0 -> 00.
- Load-use: memtoreg_e = 1, writereg_e = 9, rt_d = 9 -> stall_f = stall_d = flush_e = 1 for exactly that cycle. Set rt_d = 0 with writereg_e = 0 -> no stall.
- Branch hazards: branch_d = 1, rs_d = 4, regwrite_e = 1, writereg_e = 4 -> stall. Next cycle, instruction in M with memtoreg_m = 1, writereg_m = 4 -> stall again. A non-load in M gives forward_ad = 1 and no stall.
- MDU, MDU_LAT = 4: mdu_start_e at cycle 10, mdu_rd_d held high -> stall in cycles 10..13, released at 14. mdu_busy pattern 1111 then 0.
- Taken branch during stall: branch_taken_d = 1 with load-use active -> flush_d = 0. Stall clears -> flush_d = 1.
- Async reset at cycle 2 of an MDU op -> mdu_busy = 0 without a clock edge. With HAZARD_STALL_PERF_EN, stall_cnt = 0, then counts 3 stalled cycles -> 3.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the hazard scoreboard unit: forwarding-mux selects and
// default geometry for the register file and the MDU.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  localparam int unsigned HAZ_REG_AW  = 5;
  localparam int unsigned HAZ_MDU_LAT = 4;

endpackage

// File: rtl/hazard_scoreboard_unit_mdu_busy_tracker.sv
// MDU occupancy countdown. Busy covers the issue cycle combinationally and the
// following MDU_LAT-1 cycles from the counter; a new start always reloads.
module mdu_busy_tracker #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdu_start,
  output logic mdu_busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (mdu_start) begin
      cnt <= CNT_W'(MDU_LAT - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    mdu_busy = (cnt != '0) || mdu_start;
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: forwarding selects, load/branch/MDU
// stalls and taken-branch D flush. Optional stall counter: HAZARD_STALL_PERF_EN.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW  = HAZ_REG_AW,
  parameter int unsigned MDU_LAT = HAZ_MDU_LAT,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned PERF_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_d,
  input  logic [REG_AW-1:0] rt_d,
  input  logic [REG_AW-1:0] rs_e,
  input  logic [REG_AW-1:0] rt_e,
  input  logic              regwrite_e,
  input  logic              memtoreg_e,
  input  logic [REG_AW-1:0] writereg_e,
  input  logic              regwrite_m,
  input  logic              memtoreg_m,
  input  logic [REG_AW-1:0] writereg_m,
  input  logic              regwrite_w,
  input  logic [REG_AW-1:0] writereg_w,
  input  logic              branch_d,
  input  logic              branch_taken_d,
  input  logic              mdu_op_d,
  input  logic              mdu_rd_d,
  input  logic              mdu_start_e,
  output logic [1:0]        forward_ae,
  output logic [1:0]        forward_be,
  output logic              forward_ad,
  output logic              forward_bd,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_e,
  output logic              flush_d,
  output logic              mdu_busy
`ifdef HAZARD_STALL_PERF_EN
  ,
  output logic [PERF_W-1:0] stall_cnt
`endif
);

  logic rs_d_nz, rt_d_nz, rs_e_nz, rt_e_nz;
  logic d_hits_e, d_hits_m;
  logic stall_loaduse, stall_br_alu, stall_br_load, stall_hilo, stall_struct;
  logic stall;

  mdu_busy_tracker #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_busy_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .mdu_start (mdu_start_e),
    .mdu_busy  (mdu_busy)
  );

  always_comb begin
    rs_d_nz = (rs_d != '0);
    rt_d_nz = (rt_d != '0);
    rs_e_nz = (rs_e != '0);
    rt_e_nz = (rt_e != '0);
  end

  // M result has priority over W because it is the younger write.
  always_comb begin
    forward_ae = FWD_RF;
    if (rs_e_nz && regwrite_m && (rs_e == writereg_m)) begin
      forward_ae = FWD_M;
    end else if (rs_e_nz && regwrite_w && (rs_e == writereg_w)) begin
      forward_ae = FWD_W;
    end

    forward_be = FWD_RF;
    if (rt_e_nz && regwrite_m && (rt_e == writereg_m)) begin
      forward_be = FWD_M;
    end else if (rt_e_nz && regwrite_w && (rt_e == writereg_w)) begin
      forward_be = FWD_W;
    end

    forward_ad = rs_d_nz && regwrite_m && (rs_d == writereg_m);
    forward_bd = rt_d_nz && regwrite_m && (rt_d == writereg_m);
  end

  always_comb begin
    d_hits_e = (rs_d_nz && (rs_d == writereg_e)) || (rt_d_nz && (rt_d == writereg_e));
    d_hits_m = (rs_d_nz && (rs_d == writereg_m)) || (rt_d_nz && (rt_d == writereg_m));

    stall_loaduse = memtoreg_e && d_hits_e;
    stall_br_alu  = branch_d && regwrite_e && d_hits_e;
    stall_br_load = branch_d && memtoreg_m && d_hits_m;
    stall_hilo    = mdu_rd_d && mdu_busy;
    stall_struct  = mdu_op_d && mdu_busy;

    stall = stall_loaduse || stall_br_alu || stall_br_load || stall_hilo || stall_struct;
  end

  // A branch resolved while D is held is re-evaluated once the stall clears.
  always_comb begin
    stall_f = stall;
    stall_d = stall;
    flush_e = stall;
    flush_d = branch_taken_d && !stall;
  end

`ifdef HAZARD_STALL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_d && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end
`else
  // Counter width only matters when the counter is built.
  if (PERF_W == 0) begin : g_no_perf
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Scoreboard bench for hazard_scoreboard_unit: directed scenarios then random
// traffic, each cycle's expectations queued from a behavioural model.
module tb_hazard_scoreboard_unit;

  localparam int unsigned REG_AW  = 5;
  localparam int unsigned MDU_LAT = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned PERF_W  = 32;

  typedef struct {
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;
    logic branch_d, branch_taken_d, mdu_op_d, mdu_rd_d, mdu_start_e;
    logic rst;
  } stim_t;

  typedef struct {
    logic [1:0] fae, fbe;
    logic fad, fbd, stall, flush_d, busy;
    logic [PERF_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [REG_AW-1:0] rs_d = '0, rt_d = '0, rs_e = '0, rt_e = '0;
  logic [REG_AW-1:0] writereg_e = '0, writereg_m = '0, writereg_w = '0;
  logic regwrite_e = 1'b0, memtoreg_e = 1'b0, regwrite_m = 1'b0, memtoreg_m = 1'b0;
  logic regwrite_w = 1'b0, branch_d = 1'b0, branch_taken_d = 1'b0;
  logic mdu_op_d = 1'b0, mdu_rd_d = 1'b0, mdu_start_e = 1'b0;
  logic [1:0] forward_ae, forward_be;
  logic forward_ad, forward_bd, stall_f, stall_d, flush_e, flush_d, mdu_busy;
`ifdef HAZARD_STALL_PERF_EN
  logic [PERF_W-1:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  exp_t expq[$];

  // Model state: cycle index, most recent MDU issue cycle, stalled-cycle tally.
  int cyc = 0;
  int last_start = 0;
  bit have_start = 1'b0;
  logic [PERF_W-1:0] perf = '0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .REG_AW  (REG_AW),
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W),
    .PERF_W  (PERF_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs_d           (rs_d),
    .rt_d           (rt_d),
    .rs_e           (rs_e),
    .rt_e           (rt_e),
    .regwrite_e     (regwrite_e),
    .memtoreg_e     (memtoreg_e),
    .writereg_e     (writereg_e),
    .regwrite_m     (regwrite_m),
    .memtoreg_m     (memtoreg_m),
    .writereg_m     (writereg_m),
    .regwrite_w     (regwrite_w),
    .writereg_w     (writereg_w),
    .branch_d       (branch_d),
    .branch_taken_d (branch_taken_d),
    .mdu_op_d       (mdu_op_d),
    .mdu_rd_d       (mdu_rd_d),
    .mdu_start_e    (mdu_start_e),
    .forward_ae     (forward_ae),
    .forward_be     (forward_be),
    .forward_ad     (forward_ad),
    .forward_bd     (forward_bd),
    .stall_f        (stall_f),
    .stall_d        (stall_d),
    .flush_e        (flush_e),
    .flush_d        (flush_d),
    .mdu_busy       (mdu_busy)
`ifdef HAZARD_STALL_PERF_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  function automatic bit hit(input logic [REG_AW-1:0] src, input logic [REG_AW-1:0] dst);
    return (src != 0) && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_e(input stim_t s, input logic [REG_AW-1:0] src);
    if (s.regwrite_m && hit(src, s.writereg_m)) return 2'b10;
    if (s.regwrite_w && hit(src, s.writereg_w)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t model(input stim_t s);
    exp_t e;
    bit dep_e, dep_m;
    e.fae = fwd_e(s, s.rs_e);
    e.fbe = fwd_e(s, s.rt_e);
    e.fad = s.regwrite_m && hit(s.rs_d, s.writereg_m);
    e.fbd = s.regwrite_m && hit(s.rt_d, s.writereg_m);
    e.busy = s.mdu_start_e || (!s.rst && have_start && (cyc < last_start + int'(MDU_LAT)));
    dep_e = hit(s.rs_d, s.writereg_e) || hit(s.rt_d, s.writereg_e);
    dep_m = hit(s.rs_d, s.writereg_m) || hit(s.rt_d, s.writereg_m);
    e.stall = (s.memtoreg_e && dep_e) || (s.branch_d && s.regwrite_e && dep_e) ||
              (s.branch_d && s.memtoreg_m && dep_m) ||
              ((s.mdu_rd_d || s.mdu_op_d) && e.busy);
    e.flush_d = s.branch_taken_d && !e.stall;
    e.cnt = s.rst ? '0 : perf;
    return e;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rnd_stim();
    stim_t s;
    s.rs_d = REG_AW'($urandom_range(0, 3));
    s.rt_d = REG_AW'($urandom_range(0, 3));
    s.rs_e = REG_AW'($urandom_range(0, 3));
    s.rt_e = REG_AW'($urandom_range(0, 3));
    s.writereg_e = REG_AW'($urandom_range(0, 3));
    s.writereg_m = REG_AW'($urandom_range(0, 3));
    s.writereg_w = REG_AW'($urandom_range(0, 3));
    s.regwrite_e = 1'($urandom_range(0, 1));
    s.memtoreg_e = ($urandom_range(0, 3) == 0);
    s.regwrite_m = 1'($urandom_range(0, 1));
    s.memtoreg_m = ($urandom_range(0, 3) == 0);
    s.regwrite_w = 1'($urandom_range(0, 1));
    s.branch_d = ($urandom_range(0, 3) == 0);
    s.branch_taken_d = ($urandom_range(0, 2) == 0);
    s.mdu_op_d = ($urandom_range(0, 5) == 0);
    s.mdu_rd_d = ($urandom_range(0, 5) == 0);
    s.mdu_start_e = ($urandom_range(0, 7) == 0);
    s.rst = ($urandom_range(0, 63) == 0);
    if (s.rst) s.mdu_start_e = 1'b0;
    return s;
  endfunction

  // Reset cycles drop rst_n mid-cycle, after inputs settle, so the async path is observed.
  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rs_d = s.rs_d; rt_d = s.rt_d; rs_e = s.rs_e; rt_e = s.rt_e;
    writereg_e = s.writereg_e; writereg_m = s.writereg_m; writereg_w = s.writereg_w;
    regwrite_e = s.regwrite_e; memtoreg_e = s.memtoreg_e;
    regwrite_m = s.regwrite_m; memtoreg_m = s.memtoreg_m; regwrite_w = s.regwrite_w;
    branch_d = s.branch_d; branch_taken_d = s.branch_taken_d;
    mdu_op_d = s.mdu_op_d; mdu_rd_d = s.mdu_rd_d; mdu_start_e = s.mdu_start_e;
    if (!s.rst) rst_n = 1'b1;
    e = model(s);
    expq.push_back(e);
    if (s.rst) begin
      have_start = 1'b0;
      perf = '0;
    end else begin
      if (s.mdu_start_e) begin
        have_start = 1'b1;
        last_start = cyc;
      end
      if (e.stall && perf != '1) perf = perf + 1'b1;
    end
    cyc++;
    if (s.rst) begin
      #1;
      rst_n = 1'b0;
    end
  endtask

  task automatic chk(input string name, input logic [PERF_W-1:0] act, input logic [PERF_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("forward_ae", PERF_W'(forward_ae), PERF_W'(e.fae));
      chk("forward_be", PERF_W'(forward_be), PERF_W'(e.fbe));
      chk("forward_ad", PERF_W'(forward_ad), PERF_W'(e.fad));
      chk("forward_bd", PERF_W'(forward_bd), PERF_W'(e.fbd));
      chk("stall_f", PERF_W'(stall_f), PERF_W'(e.stall));
      chk("stall_d", PERF_W'(stall_d), PERF_W'(e.stall));
      chk("flush_e", PERF_W'(flush_e), PERF_W'(e.stall));
      chk("flush_d", PERF_W'(flush_d), PERF_W'(e.flush_d));
      chk("mdu_busy", PERF_W'(mdu_busy), PERF_W'(e.busy));
`ifdef HAZARD_STALL_PERF_EN
      chk("stall_cnt", stall_cnt, e.cnt);
`endif
    end
  end

  initial begin
    stim_t s;

    s = idle(); s.rst = 1'b1;
    drive(s);
    drive(s);

    // Forward priority M over W, then W only, then register 0.
    s = idle(); s.rs_e = 7; s.writereg_m = 7; s.writereg_w = 7;
    s.regwrite_m = 1'b1; s.regwrite_w = 1'b1;
    drive(s);
    s.regwrite_m = 1'b0;
    drive(s);
    s.rs_e = 0;
    drive(s);

    // Load-use, then zero-register no-stall.
    s = idle(); s.memtoreg_e = 1'b1; s.regwrite_e = 1'b1; s.writereg_e = 9; s.rt_d = 9;
    drive(s);
    s.rt_d = 0; s.writereg_e = 0;
    drive(s);

    // Branch on ALU result in E, then load in M, then non-load in M.
    s = idle(); s.branch_d = 1'b1; s.rs_d = 4; s.regwrite_e = 1'b1; s.writereg_e = 4;
    drive(s);
    s = idle(); s.branch_d = 1'b1; s.rs_d = 4; s.memtoreg_m = 1'b1; s.regwrite_m = 1'b1; s.writereg_m = 4;
    drive(s);
    s.memtoreg_m = 1'b0;
    drive(s);

    // MDU issue with mfhi held in D.
    s = idle(); s.mdu_rd_d = 1'b1; s.mdu_start_e = 1'b1;
    drive(s);
    s.mdu_start_e = 1'b0;
    for (int i = 0; i < 4; i++) drive(s);
    s = idle(); s.mdu_op_d = 1'b1;
    drive(s);

    // Taken branch masked by a load-use stall, then acted on.
    s = idle(); s.memtoreg_e = 1'b1; s.writereg_e = 3; s.rs_d = 3; s.branch_taken_d = 1'b1;
    drive(s);
    s.memtoreg_e = 1'b0;
    drive(s);

    // Reset in the middle of an MDU operation, then three stalled cycles.
    s = idle(); s.mdu_start_e = 1'b1;
    drive(s);
    s = idle();
    drive(s);
    s.rst = 1'b1;
    drive(s);
    s = idle(); s.memtoreg_e = 1'b1; s.writereg_e = 5; s.rs_d = 5;
    for (int i = 0; i < 3; i++) drive(s);
    s = idle();
    drive(s);
    drive(s);

    for (int i = 0; i < 400; i++) drive(rnd_stim());

    s = idle();
    drive(s);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
